// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
package bcd_pkg;

   localparam int DIGIT_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage : bcd_pkg

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added before the shift.
module bcd_add3_digit
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit_i,
   output logic [DIGIT_W-1:0] digit_o
);

   always_comb begin
      digit_o = digit_i;
      if (digit_i >= 4'd5) begin
         digit_o = digit_i + 4'd3;
      end
   end

endmodule : bcd_add3_digit

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter, one double-dabble iteration per clock.
//    state | meaning
//    IDLE  | waiting for start, result registers hold last conversion
//    SHIFT | one add-3/shift iteration per cycle, cnt_q iterations left
//    DONE  | single-cycle done pulse, start here is accepted back-to-back
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [WIDTH-1:0]          bin,
   output logic                      busy,
   output logic                      done,
   output logic [DIGIT_W*DIGITS-1:0] bcd,
   output logic                      overflow
);

   localparam int BW = DIGIT_W * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [BW-1:0]   wd_q, wd_d;
   logic            ovf_w_q, ovf_w_d;
   logic [BW-1:0]   bcd_q, bcd_d;
   logic            overflow_q, overflow_d;

   logic [BW-1:0]   adj;
   logic [BW-1:0]   wd_shift;
   logic            ovf_shift;

   for (genvar g = 0; g < DIGITS; g++) begin : g_dig
      bcd_add3_digit u_add3 (
         .digit_i (wd_q[g*DIGIT_W +: DIGIT_W]),
         .digit_o (adj[g*DIGIT_W +: DIGIT_W])
      );
   end

   // The bit leaving the top digit is a carry of 10^DIGITS; it is only tracked as overflow.
   assign wd_shift  = {adj[BW-2:0], sr_q[WIDTH-1]};
   assign ovf_shift = ovf_w_q | adj[BW-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         sr_q       <= '0;
         wd_q       <= '0;
         ovf_w_q    <= 1'b0;
         bcd_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sr_q       <= sr_d;
         wd_q       <= wd_d;
         ovf_w_q    <= ovf_w_d;
         bcd_q      <= bcd_d;
         overflow_q <= overflow_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sr_d       = sr_q;
      wd_d       = wd_q;
      ovf_w_d    = ovf_w_q;
      bcd_d      = bcd_q;
      overflow_d = overflow_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               sr_d    = bin;
               wd_d    = '0;
               ovf_w_d = 1'b0;
               cnt_d   = CW'(WIDTH);
               state_d = SHIFT;
            end else begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            sr_d    = sr_q << 1;
            wd_d    = wd_shift;
            ovf_w_d = ovf_shift;
            cnt_d   = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               bcd_d      = wd_shift;
               overflow_d = ovf_shift;
               state_d    = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy     = (state_q == SHIFT);
   assign done     = (state_q == DONE);
   assign bcd      = bcd_q;
   assign overflow = overflow_q;

endmodule : bin_to_bcd_seq
